sdram_host_port: RTL and testbench

SDRAM_HOST_PORT -- requirements
Module: sdram_host_port

---
 rtl/mem_pkg.sv | 52 +++++
 rtl/sdram_host_port_if.sv | 22 ++
 rtl/sdram_host_port.sv | 210 +++++++++++++++++++++
 tb/tb_sdram_host_port.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings, defaults and small helpers for the SDRAM host port.
package mem_pkg;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 1023;
    localparam int unsigned DEF_GAP_CYCLES     = 2;
    localparam int unsigned ADDR_W             = 32;
    localparam int unsigned DATA_W             = 32;
    localparam int unsigned HALF_W             = 16;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        size_e             size;
    } cpu_req_t;

    // Misaligned halves/words and the reserved size are rejected before touching the controller.
    function automatic logic is_bad_req(input size_e sz, input logic [1:0] a);
        case (sz)
            SZ_HALF: is_bad_req = a[0];
            SZ_WORD: is_bad_req = (a != 2'b00);
            SZ_RSVD: is_bad_req = 1'b1;
            default: is_bad_req = 1'b0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_data(input size_e sz, input logic odd,
                                                    input logic [DATA_W-1:0] buf_w);
        case (sz)
            SZ_BYTE: load_data = {24'd0, (odd ? buf_w[15:8] : buf_w[7:0])};
            SZ_HALF: load_data = {16'd0, buf_w[15:0]};
            default: load_data = buf_w;
        endcase
    endfunction

endpackage

// File: rtl/sdram_host_port_if.sv
// Controller-side request/response bundle between the host port and the SDRAM controller.
interface sdram_host_port_if;
    import mem_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              rw_req;
    logic              rw;
    logic [DATA_W-1:0] write_data;
    logic [1:0]        size;
    logic [HALF_W-1:0] read_data;
    logic              data_valid;

    modport master (
        output address, rw_req, rw, write_data, size,
        input  read_data, data_valid
    );

    modport slave (
        input  address, rw_req, rw, write_data, size,
        output read_data, data_valid
    );
endinterface

// File: rtl/sdram_host_port.sv
// Bridges single CPU loads/stores onto a 16-bit SDRAM controller, splitting words into two halves.
module sdram_host_port
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_size,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic              cpu_busy,
    sdram_host_port_if.master mem
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 2);

    state_e            state_q, state_d;
    cpu_req_t          req_q, req_d;
    logic              phase_q, phase_d;
    logic              abort_q, abort_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [1:0]        size_q, size_d;
    logic              rw_req_q, rw_req_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              cpu_err_q, cpu_err_d;
    logic              cpu_busy_q, cpu_busy_d;

    logic bad_c, word_c, timeout_c, gap_done_c;

    assign bad_c      = is_bad_req(req_q.size, req_q.addr[1:0]);
    assign word_c     = (req_q.size == SZ_WORD);
    assign timeout_c  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign gap_done_c = (GAP_CYCLES <= 1) || (cnt_q == CNT_W'(GAP_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (cpu_req) state_d = ST_REQ;
            ST_REQ:     state_d = bad_c ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (mem.data_valid)  state_d = ST_RELEASE;
                else if (timeout_c)  state_d = ST_GAP;
            end
            ST_RELEASE: if (!mem.data_valid || timeout_c) state_d = ST_GAP;
            ST_GAP: begin
                if (gap_done_c) begin
                    if (abort_q)                  state_d = ST_IDLE;
                    else if (word_c && !phase_q)  state_d = ST_REQ;
                    else                          state_d = ST_DONE;
                end
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath and output logic
    always_comb begin
        req_d        = req_q;
        phase_d      = phase_q;
        abort_d      = abort_q;
        cnt_d        = cnt_q;
        rd_buf_d     = rd_buf_q;
        address_d    = address_q;
        rw_d         = rw_q;
        write_data_d = write_data_q;
        size_d       = size_q;
        rw_req_d     = rw_req_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_ready_d  = 1'b0;
        cpu_err_d    = 1'b0;
        cpu_busy_d   = (state_d != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    req_d   = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, size: size_e'(cpu_size)};
                    phase_d = 1'b0;
                    abort_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (bad_c) begin
                    cpu_err_d = 1'b1;
                end else begin
                    address_d = req_q.addr + (phase_q ? ADDR_W'(2) : ADDR_W'(0));
                    rw_d      = req_q.we;
                    size_d    = word_c ? SZ_HALF : req_q.size;
                    // Bytes sit in [7:0]; the controller steers lanes itself.
                    if (req_q.size == SZ_BYTE)
                        write_data_d = {24'd0, req_q.wdata[7:0]};
                    else
                        write_data_d = {16'd0, (phase_q ? req_q.wdata[31:16] : req_q.wdata[15:0])};
                    rw_req_d  = 1'b1;
                    cnt_d     = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem.data_valid) begin
                    rw_req_d = 1'b0;
                    if (!req_q.we) begin
                        if (phase_q) rd_buf_d[31:16] = mem.read_data;
                        else         rd_buf_d[15:0]  = mem.read_data;
                    end
                end else if (timeout_c) begin
                    rw_req_d  = 1'b0;
                    cpu_err_d = 1'b1;
                    abort_d   = 1'b1;
                    cnt_d     = '0;
                end
            end
            ST_RELEASE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!mem.data_valid) begin
                    cnt_d = '0;
                end else if (timeout_c) begin
                    cpu_err_d = 1'b1;
                    abort_d   = 1'b1;
                    cnt_d     = '0;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (gap_done_c) begin
                    cnt_d = '0;
                    if (!abort_q) begin
                        if (word_c && !phase_q) begin
                            phase_d = 1'b1;
                        end else begin
                            cpu_ready_d = 1'b1;
                            if (!req_q.we)
                                cpu_rdata_d = load_data(req_q.size, req_q.addr[0], rd_buf_q);
                        end
                    end
                end
            end
            ST_DONE: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset clears everything, dropping rw_req immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q        <= '0;
            phase_q      <= 1'b0;
            abort_q      <= 1'b0;
            cnt_q        <= '0;
            rd_buf_q     <= '0;
            address_q    <= '0;
            rw_q         <= 1'b0;
            write_data_q <= '0;
            size_q       <= '0;
            rw_req_q     <= 1'b0;
            cpu_rdata_q  <= '0;
            cpu_ready_q  <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_busy_q   <= 1'b0;
        end else begin
            req_q        <= req_d;
            phase_q      <= phase_d;
            abort_q      <= abort_d;
            cnt_q        <= cnt_d;
            rd_buf_q     <= rd_buf_d;
            address_q    <= address_d;
            rw_q         <= rw_d;
            write_data_q <= write_data_d;
            size_q       <= size_d;
            rw_req_q     <= rw_req_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_err_q    <= cpu_err_d;
            cpu_busy_q   <= cpu_busy_d;
        end
    end

    assign cpu_rdata      = cpu_rdata_q;
    assign cpu_ready      = cpu_ready_q;
    assign cpu_err        = cpu_err_q;
    assign cpu_busy       = cpu_busy_q;
    assign mem.address    = address_q;
    assign mem.rw_req     = rw_req_q;
    assign mem.rw         = rw_q;
    assign mem.write_data = write_data_q;
    assign mem.size       = size_q;

endmodule

// File: tb/tb_sdram_host_port.sv
// Scoreboard bench for sdram_host_port: a controller model checks transactions, a monitor checks CPU responses.
module tb_sdram_host_port;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [1:0]  size;
        logic [15:0] wd;
    } txn_t;

    typedef struct {
        logic        is_err;
        logic        chk;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        cpu_busy;
    logic        mdl_silent;

    int n_cmp = 0;
    int n_bad = 0;

    txn_t        exp_txn[$];
    rsp_t        exp_rsp[$];
    logic [15:0] rd_halves[$];

    sdram_host_port_if mem_bus();

    sdram_host_port #(
        .TIMEOUT_CYCLES(1023),
        .GAP_CYCLES    (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_size (cpu_size),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .cpu_err  (cpu_err),
        .cpu_busy (cpu_busy),
        .mem      (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_txn(input logic [31:0] a, input logic rw, input logic [1:0] sz, input logic [15:0] wd);
        txn_t t;
        t.addr = a; t.rw = rw; t.size = sz; t.wd = wd;
        exp_txn.push_back(t);
    endtask

    task automatic push_rsp(input logic is_err, input logic chk, input logic [31:0] rd);
        rsp_t r;
        r.is_err = is_err; r.chk = chk; r.rdata = rd;
        exp_rsp.push_back(r);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cpu_busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (cpu_busy) check("idle_timeout_busy", 32'(cpu_busy), 32'd0);
    endtask

    task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_size  = sz;
        @(negedge clk);
        cpu_req   = 1'b0;
        cpu_wdata = 32'hFFFF_FFFF;
        cpu_addr  = 32'hFFFF_FFFF;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rw_req"},     32'(mem_bus.rw_req), 32'd0);
        check({tag, "_rw"},         32'(mem_bus.rw), 32'd0);
        check({tag, "_address"},    mem_bus.address, 32'd0);
        check({tag, "_write_data"}, mem_bus.write_data, 32'd0);
        check({tag, "_size"},       32'(mem_bus.size), 32'd0);
        check({tag, "_cpu_rdata"},  cpu_rdata, 32'd0);
        check({tag, "_cpu_ready"},  32'(cpu_ready), 32'd0);
        check({tag, "_cpu_err"},    32'(cpu_err), 32'd0);
        check({tag, "_cpu_busy"},   32'(cpu_busy), 32'd0);
    endtask

    // Controller model: checks each rw_req assertion against the expected transaction queue.
    initial begin : ctrl_model
        txn_t        e;
        int          n;
        logic [31:0] a0;
        mem_bus.data_valid = 1'b0;
        mem_bus.read_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_bus.rw_req === 1'b1) begin
                if (exp_txn.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_txn: got rw_req at address 0x%08h expected no transaction",
                             mem_bus.address);
                end else begin
                    e = exp_txn.pop_front();
                    check("txn_addr", mem_bus.address, e.addr);
                    check("txn_rw",   32'(mem_bus.rw), 32'(e.rw));
                    check("txn_size", 32'(mem_bus.size), 32'(e.size));
                    if (e.rw) check("txn_wdata", 32'(mem_bus.write_data[15:0]), 32'(e.wd));
                end
                a0 = mem_bus.address;
                if (mdl_silent) begin
                    n = 0;
                    while (mem_bus.rw_req && n < 2000) begin @(negedge clk); n++; end
                end else begin
                    repeat (2) @(negedge clk);
                    check("txn_addr_stable", mem_bus.address, a0);
                    mem_bus.read_data  = (rd_halves.size() != 0) ? rd_halves.pop_front() : 16'hDEAD;
                    mem_bus.data_valid = 1'b1;
                    repeat (2) @(negedge clk);
                    mem_bus.data_valid = 1'b0;
                    mem_bus.read_data  = '0;
                    n = 0;
                    while (mem_bus.rw_req && n < 20) begin @(negedge clk); n++; end
                    if (mem_bus.rw_req) check("txn_rw_req_release", 32'(mem_bus.rw_req), 32'd0);
                end
            end
        end
    end

    // Monitor: pops the expected response whenever the DUT signals completion or error.
    initial begin : monitor
        rsp_t r;
        forever begin
            @(negedge clk);
            if (cpu_ready || cpu_err) begin
                if (exp_rsp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got ready=%0b err=%0b expected no response",
                             cpu_ready, cpu_err);
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_ready", 32'(cpu_ready), 32'(!r.is_err));
                    check("rsp_err",   32'(cpu_err), 32'(r.is_err));
                    if (r.chk) check("rsp_rdata", cpu_rdata, r.rdata);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        reset      = 1'b0;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        cpu_size   = '0;
        mdl_silent = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // Byte store
        wait_idle();
        push_txn(32'h0003_0000, 1'b1, 2'd0, 16'h0023);
        push_rsp(1'b0, 1'b0, 32'd0);
        cpu_op(1'b1, 32'h0003_0000, 32'h0000_0023, 2'd0);

        // Byte load, odd byte
        wait_idle();
        rd_halves.push_back(16'h2423);
        push_txn(32'h0003_0001, 1'b0, 2'd0, 16'h0000);
        push_rsp(1'b0, 1'b1, 32'h0000_0024);
        cpu_op(1'b0, 32'h0003_0001, 32'd0, 2'd0);

        // Word load split into two halves
        wait_idle();
        rd_halves.push_back(16'h2827);
        rd_halves.push_back(16'h3029);
        push_txn(32'h0003_0004, 1'b0, 2'd1, 16'h0000);
        push_txn(32'h0003_0006, 1'b0, 2'd1, 16'h0000);
        push_rsp(1'b0, 1'b1, 32'h3029_2827);
        cpu_op(1'b0, 32'h0003_0004, 32'd0, 2'd2);

        // Misaligned half: error one cycle after capture, no transaction
        wait_idle();
        push_rsp(1'b1, 1'b0, 32'd0);
        cpu_op(1'b0, 32'h0003_0003, 32'd0, 2'd1);
        @(negedge clk);
        check("misalign_err_timing", 32'(cpu_err), 32'd1);

        // Word store; load data must hold across it
        wait_idle();
        push_txn(32'h0003_0008, 1'b1, 2'd1, 16'hCCDD);
        push_txn(32'h0003_000A, 1'b1, 2'd1, 16'hAABB);
        push_rsp(1'b0, 1'b0, 32'd0);
        cpu_op(1'b1, 32'h0003_0008, 32'hAABB_CCDD, 2'd2);
        wait_idle();
        check("rdata_hold_after_store", cpu_rdata, 32'h3029_2827);

        // Half load
        rd_halves.push_back(16'hBEEF);
        push_txn(32'h0003_0002, 1'b0, 2'd1, 16'h0000);
        push_rsp(1'b0, 1'b1, 32'h0000_BEEF);
        cpu_op(1'b0, 32'h0003_0002, 32'd0, 2'd1);

        // Byte load, even byte
        wait_idle();
        rd_halves.push_back(16'h1234);
        push_txn(32'h0003_0000, 1'b0, 2'd0, 16'h0000);
        push_rsp(1'b0, 1'b1, 32'h0000_0034);
        cpu_op(1'b0, 32'h0003_0000, 32'd0, 2'd0);

        // Reserved size and misaligned word
        wait_idle();
        push_rsp(1'b1, 1'b0, 32'd0);
        cpu_op(1'b0, 32'h0003_0000, 32'd0, 2'd3);
        wait_idle();
        push_rsp(1'b1, 1'b0, 32'd0);
        cpu_op(1'b1, 32'h0003_0002, 32'h1111_2222, 2'd2);

        // Timeout: controller never answers
        wait_idle();
        mdl_silent = 1'b1;
        push_txn(32'h0003_0010, 1'b0, 2'd1, 16'h0000);
        push_rsp(1'b1, 1'b0, 32'd0);
        cpu_op(1'b0, 32'h0003_0010, 32'd0, 2'd1);
        n = 0;
        while (!mem_bus.rw_req && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (mem_bus.rw_req && n < 2000) begin n++; @(negedge clk); end
        check("timeout_rw_req_cycles", 32'(n), 32'd1023);
        @(negedge clk);
        check("timeout_busy_in_gap", 32'(cpu_busy), 32'd1);
        @(negedge clk);
        check("timeout_busy_after_gap", 32'(cpu_busy), 32'd0);
        check("timeout_rdata_kept", cpu_rdata, 32'h0000_0034);

        // Reset in the middle of a word store
        wait_idle();
        push_txn(32'h0003_000C, 1'b1, 2'd1, 16'h3344);
        cpu_op(1'b1, 32'h0003_000C, 32'h1122_3344, 2'd2);
        n = 0;
        while (!mem_bus.rw_req && n < 10) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        reset      = 1'b1;
        mdl_silent = 1'b0;
        @(negedge clk);

        // Normal service after reset; the aborted store must not reappear
        wait_idle();
        rd_halves.push_back(16'h5A4B);
        push_txn(32'h0003_0005, 1'b0, 2'd0, 16'h0000);
        push_rsp(1'b0, 1'b1, 32'h0000_005A);
        cpu_op(1'b0, 32'h0003_0005, 32'd0, 2'd0);
        wait_idle();

        n = 0;
        while ((exp_rsp.size() != 0 || exp_txn.size() != 0) && n < 100) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        check("txn_queue_drained", 32'(exp_txn.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
